// File: rtl/binary_to_ternary_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : binary_to_ternary_pkg                                            |
// | Brief   : Trit codes and FSM state encodings shared with the adder path.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package binary_to_ternary_pkg;

   localparam int         TRIT_BITS = 2;
   localparam logic [1:0] TRIT_ZERO = 2'b00;
   localparam logic [1:0] TRIT_ONE  = 2'b01;
   localparam logic [1:0] TRIT_TWO  = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage : binary_to_ternary_pkg
`default_nettype wire

// File: rtl/binary_to_ternary_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : div_by_three                                                     |
// | Brief   : Combinational unsigned divide-by-3, restoring long division.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_by_three #(
   parameter int W = 7
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] q,
   output logic [1:0]   r
);

   // rem_w[i+1] is the partial remainder entering bit i; it never exceeds 2.
   logic [1:0] rem_w [0:W];

   assign rem_w[W] = 2'd0;

   for (genvar i = W - 1; i >= 0; i--) begin : g_stage
      logic [2:0] t_w;
      logic       ge_w;
      assign t_w      = {rem_w[i+1], x[i]};
      assign ge_w     = (t_w >= 3'd3);
      assign q[i]     = ge_w;
      assign rem_w[i] = ge_w ? 2'(t_w - 3'd3) : t_w[1:0];
   end

   assign r = rem_w[0];

endmodule : div_by_three
`default_nettype wire

// File: rtl/binary_to_ternary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : binary_to_ternary                                                |
// | Brief   : Iterative binary to 2-bit-per-trit converter, one trit / clock.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module binary_to_ternary
   import binary_to_ternary_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [W-1:0]           bin,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [TRIT_BITS*N-1:0] trits,
   output logic                   overflow
);

   localparam int               CNT_W  = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

   logic [1:0]             state_q,    state_d;
   logic [CNT_W-1:0]       count_q,    count_d;
   logic [W-1:0]           work_q,     work_d;
   logic [TRIT_BITS*N-1:0] trits_q,    trits_d;
   logic                   overflow_q, overflow_d;

   logic [W-1:0] div_q_w;
   logic [1:0]   div_r_w;

   div_by_three #(.W(W)) u_div (
      .x (work_q),
      .q (div_q_w),
      .r (div_r_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         work_q     <= '0;
         trits_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         work_q     <= work_d;
         trits_q    <= trits_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (inValid)             state_d = ST_CONV;
         ST_CONV: if (count_q == C_LAST)   state_d = ST_DONE;
         ST_DONE: if (outReady)            state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d    = count_q;
      work_d     = work_q;
      trits_d    = trits_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: begin
            if (inValid) begin
               work_d  = bin;
               count_d = '0;
               trits_d = '0;
            end
         end
         ST_CONV: begin
            work_d  = div_q_w;
            count_d = count_q + 1'b1;
            for (int i = 0; i < N; i++) begin
               if (count_q == CNT_W'(i)) trits_d[TRIT_BITS*i +: TRIT_BITS] = div_r_w;
            end
            // Any quotient left after the last trit means bin did not fit in N trits.
            if (count_q == C_LAST) overflow_d = (div_q_w != '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      inReady  = (state_q == ST_IDLE);
      outValid = (state_q == ST_DONE);
      trits    = trits_q;
      overflow = overflow_q;
   end

endmodule : binary_to_ternary
`default_nettype wire

// File: tb/tb_binary_to_ternary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_binary_to_ternary                                             |
// | Brief   : Directed self-checking bench for binary_to_ternary (N=4, W=7).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_binary_to_ternary;

   localparam int N = 4;
   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         inValid;
   logic         inReady;
   logic [W-1:0] bin;
   logic         outValid;
   logic         outReady;
   logic [7:0]   trits;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   binary_to_ternary #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady),
      .bin      (bin),
      .outValid (outValid),
      .outReady (outReady),
      .trits    (trits),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Arithmetic reference: {overflow, trits} by repeated % and /.
   function automatic logic [8:0] model(input int v);
      logic [7:0] t;
      int         x;
      x = v;
      for (int i = 0; i < N; i++) begin
         t[2*i +: 2] = 2'(x % 3);
         x = x / 3;
      end
      return {(x != 0), t};
   endfunction

   // Accept v, wait for the result, then consume it with a one-cycle outReady.
   task automatic run_one(input logic [W-1:0] v, output logic [7:0] t, output logic o,
                          output int lat);
      int w;
      w = 0;
      while (!inReady && w < 20) begin
         tick();
         w++;
      end
      total++;
      if (inReady !== 1'b1) begin
         bad++;
         $display("FAIL run_one_ready: inReady=%b required 1", inReady);
      end
      inValid = 1'b1;
      bin     = v;
      tick();
      inValid = 1'b0;
      lat     = 0;
      while (!outValid && lat < 20) begin
         tick();
         lat++;
      end
      t        = trits;
      o        = overflow;
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b0;
      bin      = '0;
      tick();
      tick();
      rst = 1'b0;
      total += 4;
      if (inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady: got %b want 1", inReady); end
      if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid: got %b want 0", outValid); end
      if (trits !== 8'h00) begin bad++; $display("FAIL reset_trits: got %h want 00", trits); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_basic;
      logic [7:0] t;
      logic       o;
      int         lat;
      run_one(7'd5, t, o, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
      if (t !== 8'b00000110) begin bad++; $display("FAIL basic_trits: got %b want 00000110", t); end
      if (o !== 1'b0) begin bad++; $display("FAIL basic_overflow: got %b want 0", o); end
   endtask

   task automatic test_boundaries;
      logic [W-1:0] vin  [4] = '{7'd80, 7'd81, 7'd127, 7'd0};
      logic [7:0]   vexp [4] = '{8'b10101010, 8'h00, 8'b01100001, 8'h00};
      logic         vovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0]   t;
      logic         o;
      int           lat;
      for (int i = 0; i < 4; i++) begin
         run_one(vin[i], t, o, lat);
         total += 3;
         if (lat !== 4) begin bad++; $display("FAIL bound_latency bin=%0d: got %0d want 4", vin[i], lat); end
         if (t !== vexp[i]) begin bad++; $display("FAIL bound_trits bin=%0d: got %b want %b", vin[i], t, vexp[i]); end
         if (o !== vovf[i]) begin bad++; $display("FAIL bound_overflow bin=%0d: got %b want %b", vin[i], o, vovf[i]); end
      end
   endtask

   task automatic test_backpressure;
      inValid = 1'b1;
      bin     = 7'd5;
      tick();
      inValid = 1'b0;
      repeat (4) tick();
      total++;
      if (outValid !== 1'b1) begin bad++; $display("FAIL bp_outValid_rise: got %b want 1", outValid); end
      inValid = 1'b1;
      bin     = 7'd80;
      for (int c = 0; c < 10; c++) begin
         total += 4;
         if (outValid !== 1'b1) begin bad++; $display("FAIL bp_hold_outValid c=%0d: got %b want 1", c, outValid); end
         if (inReady !== 1'b0) begin bad++; $display("FAIL bp_hold_inReady c=%0d: got %b want 0", c, inReady); end
         if (trits !== 8'b00000110) begin bad++; $display("FAIL bp_hold_trits c=%0d: got %b want 00000110", c, trits); end
         if (overflow !== 1'b0) begin bad++; $display("FAIL bp_hold_overflow c=%0d: got %b want 0", c, overflow); end
         tick();
      end
      outReady = 1'b1;
      tick();
      inValid  = 1'b0;
      outReady = 1'b0;
      total += 2;
      if (inReady !== 1'b1) begin bad++; $display("FAIL bp_release_inReady: got %b want 1", inReady); end
      if (outValid !== 1'b0) begin bad++; $display("FAIL bp_release_outValid: got %b want 0", outValid); end
   endtask

   task automatic test_reset_mid_conv;
      logic [7:0] t;
      logic       o;
      int         lat;
      int         seen;
      inValid = 1'b1;
      bin     = 7'd100;
      tick();
      inValid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total += 4;
      if (inReady !== 1'b1) begin bad++; $display("FAIL midrst_inReady: got %b want 1", inReady); end
      if (outValid !== 1'b0) begin bad++; $display("FAIL midrst_outValid: got %b want 0", outValid); end
      if (trits !== 8'h00) begin bad++; $display("FAIL midrst_trits: got %h want 00", trits); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
      seen = 0;
      repeat (6) begin
         tick();
         if (outValid) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen); end
      run_one(7'd7, t, o, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL midrst_latency: got %0d want 4", lat); end
      if (t !== 8'b00001001) begin bad++; $display("FAIL midrst_trits7: got %b want 00001001", t); end
      if (o !== 1'b0) begin bad++; $display("FAIL midrst_overflow7: got %b want 0", o); end
   endtask

   task automatic test_back_to_back;
      logic [8:0] exp;
      int         lat;
      int         gap;
      int         last_accept;
      int         cyc;
      inValid     = 1'b1;
      outReady    = 1'b1;
      cyc         = 0;
      last_accept = -1;
      for (int v = 0; v < 128; v++) begin
         bin = 7'(v);
         while (!inReady && cyc < 5000) begin
            tick();
            cyc++;
         end
         tick();
         cyc++;
         if (last_accept >= 0) begin
            gap = cyc - last_accept;
            total++;
            if (gap !== N + 2) begin bad++; $display("FAIL b2b_throughput v=%0d: got %0d want %0d", v, gap, N + 2); end
         end
         last_accept = cyc;
         total++;
         if (inReady !== 1'b0) begin bad++; $display("FAIL b2b_inReady_busy v=%0d: got %b want 0", v, inReady); end
         lat = 0;
         while (!outValid && lat < 20) begin
            tick();
            cyc++;
            lat++;
         end
         exp = model(v);
         total += 3;
         if (lat !== N) begin bad++; $display("FAIL b2b_latency v=%0d: got %0d want %0d", v, lat, N); end
         if (trits !== exp[7:0]) begin bad++; $display("FAIL b2b_trits v=%0d: got %b want %b", v, trits, exp[7:0]); end
         if (overflow !== exp[8]) begin bad++; $display("FAIL b2b_overflow v=%0d: got %b want %b", v, overflow, exp[8]); end
         tick();
         cyc++;
         total++;
         if (inReady !== 1'b1) begin bad++; $display("FAIL b2b_inReady_idle v=%0d: got %b want 1", v, inReady); end
      end
      inValid  = 1'b0;
      outReady = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_backpressure();
      test_reset_mid_conv();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_binary_to_ternary
`default_nettype wire
